// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle of the register-reservation scoreboard.
// master = pipeline side (decode + writeback), slave = scoreboard.
interface reg_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int IDX_W = $clog2(NREG)
);
    logic [IDX_W-1:0] r0num_i;
    logic             r0valid_i;
    logic [IDX_W-1:0] r1num_i;
    logic             r1valid_i;
    logic [IDX_W-1:0] rdnum_i;
    logic             rdcheck_i;
    logic             rdreserve_i;
    logic             rsreserved_o;
    logic [IDX_W-1:0] wbnum_i;
    logic             wbrelease_i;
    logic             flush_i;
    logic             busy_o;
    logic [NREG-1:0]  reserved_mask_o;
    logic             err_o;

    modport master (
        output r0num_i, r0valid_i, r1num_i, r1valid_i, rdnum_i, rdcheck_i, rdreserve_i,
               wbnum_i, wbrelease_i, flush_i,
        input  rsreserved_o, busy_o, reserved_mask_o, err_o
    );

    modport slave (
        input  r0num_i, r0valid_i, r1num_i, r1valid_i, rdnum_i, rdcheck_i, rdreserve_i,
               wbnum_i, wbrelease_i, flush_i,
        output rsreserved_o, busy_o, reserved_mask_o, err_o
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-reservation scoreboard: per-register in-flight write counters, RAW/saturation stall.
// Optional SCOREBOARD_BYPASS_EN lets a same-cycle writeback release clear the hazard immediately.

// One in-flight counter per architectural register.
module reg_scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (flush_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == MAX) err_o = 1'b1;
            else              cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_o = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_scoreboard_if.slave  sb
);
    localparam int               IDX_W = $clog2(NREG);
    localparam logic [CNT_W-1:0] MAX   = '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            err_pulse;
    logic [NREG-1:0]            mask;
    logic                       err_q, err_d;

    // x0 is hard-wired zero: never counted, never flagged.
    assign cnt[0]       = '0;
    assign err_pulse[0] = 1'b0;

    generate
        for (genvar i = 1; i < NREG; i++) begin : g_reg
            logic inc, dec;
            assign inc = sb.rdreserve_i && (sb.rdnum_i == IDX_W'(i));
            assign dec = sb.wbrelease_i && (sb.wbnum_i == IDX_W'(i));
            reg_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .inc_i   (inc),
                .dec_i   (dec),
                .flush_i (sb.flush_i),
                .cnt_o   (cnt[i]),
                .err_o   (err_pulse[i])
            );
        end
        for (genvar i = 0; i < NREG; i++) begin : g_mask
            assign mask[i] = |cnt[i];
        end
    endgenerate

    logic [CNT_W-1:0] c0, c1, cd;
    logic             haz0, haz1, sat;

    assign c0 = cnt[sb.r0num_i];
    assign c1 = cnt[sb.r1num_i];
    assign cd = cnt[sb.rdnum_i];

`ifdef SCOREBOARD_BYPASS_EN
    logic wb0, wb1, wbd;
    assign wb0  = sb.wbrelease_i && (sb.wbnum_i == sb.r0num_i);
    assign wb1  = sb.wbrelease_i && (sb.wbnum_i == sb.r1num_i);
    assign wbd  = sb.wbrelease_i && (sb.wbnum_i == sb.rdnum_i);
    // Last write retiring now: regfile forwards the data, so no stall.
    assign haz0 = sb.r0valid_i && (c0 != '0) && !(wb0 && (c0 == CNT_W'(1)));
    assign haz1 = sb.r1valid_i && (c1 != '0) && !(wb1 && (c1 == CNT_W'(1)));
    assign sat  = sb.rdcheck_i && (cd == MAX) && !wbd;
`else
    assign haz0 = sb.r0valid_i && (c0 != '0);
    assign haz1 = sb.r1valid_i && (c1 != '0);
    assign sat  = sb.rdcheck_i && (cd == MAX);
`endif

    // rdreserve_i deliberately absent here: decode gates it with this output.
    assign sb.rsreserved_o    = haz0 || haz1 || sat;
    assign sb.reserved_mask_o = mask;
    assign sb.busy_o          = |mask;

    assign err_d = err_q || (|err_pulse);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign sb.err_o = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs per cycle, a negedge monitor pops and compares.
module tb_reg_scoreboard;
`ifdef SCOREBOARD_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        string       nm;
        int          cyc;
        logic        rsv;
        logic        busy;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    reg_scoreboard_if #(.NREG(32)) sb ();

    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || sb.rsreserved_o !== e.rsv || sb.busy_o !== e.busy ||
                sb.reserved_mask_o !== e.mask || sb.err_o !== e.err) begin
                errors++;
                $display("FAIL %s (cyc %0d/%0d): got rsv=%0b busy=%0b mask=%h err=%0b, want rsv=%0b busy=%0b mask=%h err=%0b",
                         e.nm, cyc, e.cyc, sb.rsreserved_o, sb.busy_o, sb.reserved_mask_o, sb.err_o,
                         e.rsv, e.busy, e.mask, e.err);
            end
        end
    end

    task automatic drive(input logic [4:0] r0n, input logic r0v, input logic [4:0] r1n, input logic r1v,
                         input logic [4:0] rdn, input logic rdc, input logic rdr,
                         input logic [4:0] wbn, input logic wbr, input logic fl);
        sb.r0num_i = r0n; sb.r0valid_i = r0v;
        sb.r1num_i = r1n; sb.r1valid_i = r1v;
        sb.rdnum_i = rdn; sb.rdcheck_i = rdc; sb.rdreserve_i = rdr;
        sb.wbnum_i = wbn; sb.wbrelease_i = wbr;
        sb.flush_i = fl;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string nm, input logic rsv, input logic [31:0] mask, input logic err);
        exp_t e;
        e.nm = nm; e.cyc = cyc; e.rsv = rsv; e.busy = (mask != 32'h0); e.mask = mask; e.err = err;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        tick();
        expect_out("reset", 1'b0, 32'h0, 1'b0); tick();
        rst_n = 1'b1;

        // Reserve x5, RAW lookup next cycle, release and recovery.
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("res5", 1'b0, 32'h0, 1'b0); tick();
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("raw5", 1'b1, 32'h20, 1'b0); tick();
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        expect_out("wb5", !BYP, 32'h20, 1'b0); tick();
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("after_wb5", 1'b0, 32'h0, 1'b0); tick();

        // Same-index reserve+release keeps count[7]=1.
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("res7", 1'b0, 32'h0, 1'b0); tick();
        drive(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        expect_out("same7_lookup", !BYP, 32'h80, 1'b0); tick();
        drive(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("same7_hold", 1'b1, 32'h80, 1'b0); tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        expect_out("rel7", 1'b0, 32'h80, 1'b0); tick();
        idle();
        expect_out("idle7", 1'b0, 32'h0, 1'b0); tick();

        // Saturate x3, forced 4th reserve, then drain.
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("res3a", 1'b0, 32'h0, 1'b0); tick();
        expect_out("res3b", 1'b0, 32'h8, 1'b0); tick();
        expect_out("res3c", 1'b0, 32'h8, 1'b0); tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("sat3", 1'b1, 32'h8, 1'b0); tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("force3", 1'b1, 32'h8, 1'b0); tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("sat_err", 1'b1, 32'h8, 1'b1); tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        expect_out("sat_byp", !BYP, 32'h8, 1'b1); tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        expect_out("rel3a", 1'b0, 32'h8, 1'b1); tick();
        expect_out("rel3b", 1'b0, 32'h8, 1'b1); tick();
        idle();
        expect_out("rel3c", 1'b0, 32'h0, 1'b1); tick();

        rst_n = 1'b0;
        expect_out("rst_mid", 1'b0, 32'h0, 1'b0); tick();
        rst_n = 1'b1;

        // Flush discards a concurrent reserve; lookups in the flush cycle see old counts.
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("res1", 1'b0, 32'h0, 1'b0); tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("res2", 1'b0, 32'h2, 1'b0); tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("res9", 1'b0, 32'h6, 1'b0); tick();
        drive(5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
        expect_out("flush", 1'b1, 32'h206, 1'b0); tick();
        drive(5'd4, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("post_flush", 1'b0, 32'h0, 1'b0); tick();

        // x0 is inert; release at zero is a sticky error cleared only by reset.
        drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        expect_out("x0_op", 1'b0, 32'h0, 1'b0); tick();
        idle();
        expect_out("x0_noerr", 1'b0, 32'h0, 1'b0); tick();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
        expect_out("rel6", 1'b0, 32'h0, 1'b0); tick();
        idle();
        expect_out("err6", 1'b0, 32'h0, 1'b1); tick();
        expect_out("err6_sticky", 1'b0, 32'h0, 1'b1); tick();
        rst_n = 1'b0;
        expect_out("rst_clr", 1'b0, 32'h0, 1'b0); tick();
        rst_n = 1'b1;
        expect_out("post_rst", 1'b0, 32'h0, 1'b0); tick();

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish by time %0t", $time);
        $fatal(1);
    end
endmodule
